hazard_ctrl_unit: RTL
=====================

Name: hazard_ctrl_unit

Overview:
Parametrised pipeline hazard controller for the 5-stage MIPS core. It combines three functions:
- operand forwarding selects for the instruction in ID;
- a counter-driven load-use / slow-memory stall FSM;
- a multi-cycle redirect flush sequencer.

It sits beside the ID stage and drives the PC enable, the IF/ID enable/flush and the ID/EX bubble insertion.

Parameters:
REG_AW, 5, register address width; register 0 is hardwired zero and never a hazard source.
LOAD_LAT, 1, stall cycles required after a load-use match (1..15).
FLUSH_DEPTH, 1, cycles flush_ifid stays asserted per redirect (1..7).
CNT_W, 16, width of performance counters (optional feature only).

Ports:
clk  in  1  pipeline clock
rst_n  in  1  reset, asynchronous assert, active-low
id_rs, id_rt  in  REG_AW  source registers of the instruction in ID
id_use_rs, id_use_rt  in  1  instruction in ID actually reads rs / rt
ex_rd  in  REG_AW  destination of the instruction in EX
ex_reg_wen  in  1  EX instruction writes the register file
ex_mem_read  in  1  EX instruction is a load
mem_rd  in  REG_AW  destination of the instruction in MEM
mem_reg_wen  in  1  MEM instruction writes the register file
mem_busy  in  1  data memory not ready; extends a running stall
redirect  in  1  taken branch or jump resolved this cycle
fwd_a, fwd_b  out  2  operand select: 00 regfile, 01 from MEM, 10 from EX
stall_pc  out  1  hold PC
stall_ifid  out  1  hold IF/ID register
bubble_idex  out  1  load NOP controls into ID/EX
flush_ifid  out  1  clear IF/ID register
stall_cnt, flush_cnt  out  CNT_W  performance counters (optional feature)

Behaviour:
- Reset (rst_n low): state IDLE, counters 0. Every control and forwarding output is forced to 0 while rst_n is low. Release is synchronous to the next clk edge.
- Match rule: exM_s = ex_reg_wen & ex_rd!=0 & id_use_rs & ex_rd==id_rs. mmM_s is the same rule using the mem_* inputs. Matches on rt are formed the same way.
- Forwarding (combinational, IDLE only):
  - fwd_a = 10 if exM_s & !ex_mem_read; else 01 if mmM_s; else 00.
  - fwd_b is the same rule on rt.
  - EX has priority over MEM.
  - In STALL or FLUSH, fwd_a and fwd_b are 00.
- Load-use detection: lu = ex_mem_read & (exM_s | exM_t).
- FSM states: IDLE, STALL, FLUSH. Down-counter cnt is 4 bits.
  - IDLE, redirect=1: flush_ifid=1 this cycle. If FLUSH_DEPTH>1, go to FLUSH with cnt=FLUSH_DEPTH-1. Redirect wins over lu; the squashed instruction is not stalled.
  - IDLE, lu=1 (no redirect): stall_pc=stall_ifid=bubble_idex=1 this cycle. If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1.
  - STALL: all three stall outputs=1.
    - cnt decrements each cycle unless mem_busy=1 (count frozen).
    - Return to IDLE after the cycle where cnt==1 and mem_busy=0.
    - redirect in STALL: abort the stall and apply the IDLE redirect rule in the same cycle; stall outputs drop that cycle.
  - FLUSH: flush_ifid=1; cnt decrements; return to IDLE after cnt==1.
    - redirect in FLUSH reloads cnt=FLUSH_DEPTH-1; FLUSH_DEPTH==1 returns to IDLE.
- Mutual exclusion: flush_ifid never asserts together with stall_ifid.
- Latency: detection outputs are same-cycle (Mealy). Continuation cycles are registered state.
- Zero register: rd==0 never causes a stall or a forward.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: stall_cnt increments on every cycle with stall_pc=1; flush_cnt increments on every cycle with flush_ifid=1. Both saturate at all-ones and reset to 0.
- Undefined: both ports are present but tied to 0, and no counter flops are inferred.

Test Plan:
- LOAD_LAT=2; lw $5 in EX (ex_mem_read=1, ex_rd=5), id_rs=5, id_use_rs=1 -> stall_pc/stall_ifid/bubble_idex=1 for exactly 2 cycles, then 0; fwd_a=00 throughout.
- LOAD_LAT=2; same load with mem_busy=1 for 3 cycles from the 2nd stall cycle -> stall held 5 cycles total, released the cycle after mem_busy falls with cnt==1.
- ex_rd=7 ALU write, mem_rd=7 write, id_rs=7 -> fwd_a=10. With ex_reg_wen=0 -> fwd_a=01. With ex_rd=mem_rd=0 -> fwd_a=00 and no stall.
- FLUSH_DEPTH=3; redirect pulse 1 cycle -> flush_ifid=1 for 3 cycles. A 2nd redirect in cycle 2 -> flush extends to cycle 4.
- Redirect and lu together in IDLE -> flush_ifid=1, stall outputs 0. Redirect arriving mid-STALL -> stall ends that cycle, flush starts.
- HAZARD_PERF_CNT_EN defined, CNT_W=4; 20 stall cycles -> stall_cnt=15 (saturated). rst_n low mid-FLUSH -> all outputs 0 immediately, counters 0.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage MIPS core: ID-stage operand
// forwarding selects, load-use / slow-memory stall sequencing and
// multi-cycle redirect flush sequencing.
// Optional feature macro: HAZARD_PERF_CNT_EN (stall/flush performance counters).
module hazard_ctrl_unit #(
   parameter int unsigned REG_AW      = 5,
   parameter int unsigned LOAD_LAT    = 1,
   parameter int unsigned FLUSH_DEPTH = 1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_reg_wen,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_reg_wen,
   input  logic              mem_busy,
   input  logic              redirect,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              stall_pc,
   output logic              stall_ifid,
   output logic              bubble_idex,
   output logic              flush_ifid,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef enum logic [1:0] {IDLE, STALL, FLUSH} state_t;

   localparam logic [3:0] LL_RELOAD = 4'(LOAD_LAT - 1);
   localparam logic [3:0] FD_RELOAD = 4'(FLUSH_DEPTH - 1);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;

   logic ex_m_s, ex_m_t, mem_m_s, mem_m_t, lu;
   logic [1:0] fa, fb;
   logic stall_raw, flush_raw;

   // Register-match terms; register 0 is never a hazard source.
   always_comb begin
      ex_m_s  = ex_reg_wen  && (ex_rd  != '0) && id_use_rs && (ex_rd  == id_rs);
      ex_m_t  = ex_reg_wen  && (ex_rd  != '0) && id_use_rt && (ex_rd  == id_rt);
      mem_m_s = mem_reg_wen && (mem_rd != '0) && id_use_rs && (mem_rd == id_rs);
      mem_m_t = mem_reg_wen && (mem_rd != '0) && id_use_rt && (mem_rd == id_rt);
      lu      = ex_mem_read && (ex_m_s || ex_m_t);
   end

   // State and down-counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic and Mealy control outputs; a redirect always beats a stall.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fa        = 2'b00;
      fb        = 2'b00;
      stall_raw = 1'b0;
      flush_raw = 1'b0;
      case (state)
         IDLE: begin
            if (ex_m_s && !ex_mem_read) fa = 2'b10;
            else if (mem_m_s)           fa = 2'b01;
            if (ex_m_t && !ex_mem_read) fb = 2'b10;
            else if (mem_m_t)           fb = 2'b01;
            if (redirect) begin
               flush_raw = 1'b1;
               if (FLUSH_DEPTH > 1) begin
                  state_nxt = FLUSH;
                  cnt_nxt   = FD_RELOAD;
               end
            end else if (lu) begin
               stall_raw = 1'b1;
               if (LOAD_LAT > 1) begin
                  state_nxt = STALL;
                  cnt_nxt   = LL_RELOAD;
               end
            end
         end
         STALL: begin
            if (redirect) begin
               flush_raw = 1'b1;
               if (FLUSH_DEPTH > 1) begin
                  state_nxt = FLUSH;
                  cnt_nxt   = FD_RELOAD;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               stall_raw = 1'b1;
               if (!mem_busy) begin
                  if (cnt == 4'd1) state_nxt = IDLE;
                  else             cnt_nxt   = cnt - 4'd1;
               end
            end
         end
         FLUSH: begin
            flush_raw = 1'b1;
            if (redirect) begin
               if (FLUSH_DEPTH > 1) cnt_nxt   = FD_RELOAD;
               else                 state_nxt = IDLE;
            end else if (cnt == 4'd1) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // All controls are held low for as long as reset is asserted.
   always_comb begin
      fwd_a       = rst_n ? fa : 2'b00;
      fwd_b       = rst_n ? fb : 2'b00;
      stall_pc    = rst_n && stall_raw;
      stall_ifid  = rst_n && stall_raw;
      bubble_idex = rst_n && stall_raw;
      flush_ifid  = rst_n && flush_raw;
   end

`ifdef HAZARD_PERF_CNT_EN
   // Saturating counts of stalled and flushed cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_pc && (stall_cnt != '1))   stall_cnt <= stall_cnt + 1'b1;
         if (flush_ifid && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      end
   end
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
